uart_frame_parser: RTL and testbench

Sits directly downstream of the UART byte receiver and consumes its oValid/oData byte stream. It hunts for a sync byte, collects a fixed-length payload, checks an XOR checksum and presents the whole payload as one parallel word with a one-cycle strobe. It also flags checksum errors and inter-byte timeouts so the control logic can drop broken frames.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_frame_parser_strobe_edge.sv | 21 ++
 rtl/uart_frame_parser.sv | 130 +++++++++++++
 tb/tb_uart_frame_parser.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path.
// Frame parser state encoding and receiver framing defaults.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } frame_state_t;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

  localparam int unsigned RX_OVERSAMPLE = 16;
  localparam int unsigned RX_DATA_BITS  = 8;
  localparam int unsigned RX_STOP_BITS  = 1;

endpackage

// File: rtl/uart_frame_parser_strobe_edge.sv
// Rising-edge detector for a level-held valid.
// One pulse per low-to-high transition, however long the level stays high.
module strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_pulse
);

  logic lvl_q;
  logic lvl_d;

  assign lvl_d   = i_level;
  assign o_pulse = i_level & ~lvl_q;

  always_ff @(posedge clk) begin
    if (!rst) lvl_q <= 1'b0;
    else      lvl_q <= lvl_d;
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Sync-byte framed payload parser with XOR checksum and timeout.
// Presents each good payload as one parallel word with a strobe.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         PAYLOAD_LEN = 4,
  parameter int         TIMEOUT_CYC = 5000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iValid,
  input  logic [7:0]               iData,
  output logic                     oFrameValid,
  output logic [8*PAYLOAD_LEN-1:0] oPayload,
  output logic                     oCrcErr,
  output logic                     oTimeout,
  output logic                     oBusy
);

  localparam int         PW       = 8 * PAYLOAD_LEN;
  localparam logic [4:0] IDX_LAST = 5'(PAYLOAD_LEN - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  frame_state_t state_q, state_d;
  logic [4:0]   idx_q, idx_d;
  logic [7:0]   acc_q, acc_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [PW-1:0] shadow_q, shadow_d;
  logic [PW-1:0] pay_q, pay_d;
  logic         fv_q, fv_d;
  logic         crc_q, crc_d;
  logic         to_q, to_d;
  logic         ev;

  strobe_edge u_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (iValid),
    .o_pulse (ev)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    pay_d    = pay_q;
    fv_d     = 1'b0;
    crc_d    = 1'b0;
    to_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (ev && iData == SYNC_BYTE) begin
          state_d = ST_PAYLOAD;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ST_PAYLOAD: begin
        if (ev) begin
          for (int i = 0; i < PAYLOAD_LEN; i++)
            if (idx_q == 5'(i)) shadow_d[8*i +: 8] = iData;
          acc_d = acc_q ^ iData;
          idx_d = idx_q + 5'd1;
          if (idx_q == IDX_LAST) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (ev) begin
          state_d = ST_IDLE;
          if (iData == acc_q) begin
            pay_d = shadow_q;
            fv_d  = 1'b1;
          end else begin
            crc_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An event always beats a coinciding timeout.
    if (state_q != ST_IDLE) begin
      if (ev) begin
        cnt_d = '0;
      end else if (cnt_q == TMO_LAST) begin
        to_d    = 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      pay_q    <= '0;
      fv_q     <= 1'b0;
      crc_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      pay_q    <= pay_d;
      fv_q     <= fv_d;
      crc_q    <= crc_d;
      to_q     <= to_d;
    end
  end

  assign oFrameValid = fv_q;
  assign oCrcErr     = crc_q;
  assign oTimeout    = to_q;
  assign oPayload    = pay_q;
  assign oBusy       = (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser.
// Expected strobes queued at stimulus time, checked by a strobe monitor.
module tb_uart_frame_parser;

  localparam logic [2:0] K_FV  = 3'b100;
  localparam logic [2:0] K_CRC = 3'b010;
  localparam logic [2:0] K_TO  = 3'b001;
  localparam logic [2:0] K_NONE = 3'b000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iValid = 1'b0;
  logic [7:0]  iData = 8'h00;
  logic        oFrameValid;
  logic [31:0] oPayload;
  logic        oCrcErr;
  logic        oTimeout;
  logic        oBusy;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] pay;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  logic [31:0] last_good = 32'h0;

  uart_frame_parser dut (
    .clk         (clk),
    .rst         (rst),
    .iValid      (iValid),
    .iData       (iData),
    .oFrameValid (oFrameValid),
    .oPayload    (oPayload),
    .oCrcErr     (oCrcErr),
    .oTimeout    (oTimeout),
    .oBusy       (oBusy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    logic [2:0] got;
    got = {oFrameValid, oCrcErr, oTimeout};
    if (rst && got != 3'b000) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got %b at cycle %0d, required none",
                 got, cyc);
      end else begin
        e = sb.pop_front();
        if (got !== e.kind) begin
          errors++;
          $display("FAIL strobe_kind: got %b, required %b", got, e.kind);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL strobe_cycle: got %0d, required %0d", cyc, e.cyc);
        end
        checks++;
        if (oPayload !== e.pay) begin
          errors++;
          $display("FAIL strobe_payload: got %h, required %h", oPayload, e.pay);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap,
                           input logic [2:0] kind, input logic [31:0] pay,
                           input int unsigned ofs);
    @(negedge clk);
    iValid = 1'b1;
    iData  = b;
    if (kind != K_NONE) sb.push_back('{kind, pay, cyc + ofs});
    repeat (hold) @(negedge clk);
    iValid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d strobes pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_busy(input string name, input logic req);
    checks++;
    if (oBusy !== req) begin
      errors++;
      $display("FAIL %s_busy: got %b, required %b", name, oBusy, req);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    iValid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({oFrameValid, oCrcErr, oTimeout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b, required 000",
               {oFrameValid, oCrcErr, oTimeout});
    end
    checks++;
    if (oPayload !== 32'h0) begin
      errors++;
      $display("FAIL reset_payload: got %h, required 00000000", oPayload);
    end
    check_busy("reset", 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_frame;
    send_byte(8'hA5, 3, 2, K_NONE, 0, 0);
    check_busy("good_sync", 1'b1);
    send_byte(8'h11, 3, 2, K_NONE, 0, 0);
    send_byte(8'h22, 3, 2, K_NONE, 0, 0);
    send_byte(8'h33, 3, 2, K_NONE, 0, 0);
    send_byte(8'h44, 3, 2, K_NONE, 0, 0);
    send_byte(8'h44, 3, 2, K_FV, 32'h44332211, 1);
    last_good = 32'h44332211;
    drain("good");
    check_busy("good_end", 1'b0);
  endtask

  task automatic test_crc_error;
    send_byte(8'hA5, 3, 2, K_NONE, 0, 0);
    send_byte(8'h11, 3, 2, K_NONE, 0, 0);
    send_byte(8'h22, 3, 2, K_NONE, 0, 0);
    send_byte(8'h33, 3, 2, K_NONE, 0, 0);
    send_byte(8'h44, 3, 2, K_NONE, 0, 0);
    send_byte(8'h45, 3, 2, K_CRC, last_good, 1);
    drain("crc");
  endtask

  task automatic test_sync_hunt;
    send_byte(8'h00, 2, 1, K_NONE, 0, 0);
    send_byte(8'hFF, 1, 1, K_NONE, 0, 0);
    send_byte(8'h5A, 2, 3, K_NONE, 0, 0);
    check_busy("hunt_idle", 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'hA5, 2, 1, K_NONE, 0, 0);
    send_byte(8'hA5, 2, 1, K_CRC, last_good, 1);
    drain("hunt_crc");
    for (int i = 0; i < 5; i++) send_byte(8'hA5, 1, 1, K_NONE, 0, 0);
    send_byte(8'h00, 1, 1, K_FV, 32'hA5A5A5A5, 1);
    last_good = 32'hA5A5A5A5;
    drain("hunt_good");
  endtask

  task automatic test_timeout;
    send_byte(8'hA5, 3, 2, K_NONE, 0, 0);
    send_byte(8'h11, 3, 2, K_NONE, 0, 0);
    send_byte(8'h22, 3, 1, K_TO, last_good, 5001);
    check_busy("tmo_wait", 1'b1);
    repeat (5000) @(negedge clk);
    drain("tmo");
    check_busy("tmo_after", 1'b0);
    send_byte(8'hA5, 3, 2, K_NONE, 0, 0);
    send_byte(8'h01, 3, 2, K_NONE, 0, 0);
    send_byte(8'h02, 3, 2, K_NONE, 0, 0);
    send_byte(8'h03, 3, 2, K_NONE, 0, 0);
    send_byte(8'h04, 3, 2, K_NONE, 0, 0);
    send_byte(8'h04, 3, 2, K_FV, 32'h04030201, 1);
    last_good = 32'h04030201;
    drain("tmo_next");
  endtask

  task automatic test_mid_reset;
    send_byte(8'hA5, 3, 2, K_NONE, 0, 0);
    send_byte(8'h11, 3, 2, K_NONE, 0, 0);
    send_byte(8'h22, 3, 2, K_NONE, 0, 0);
    check_busy("mid_pre", 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_busy("mid_rst", 1'b0);
    checks++;
    if (oPayload !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst_payload: got %h, required 00000000", oPayload);
    end
    rst = 1'b1;
    last_good = 32'h0;
    send_byte(8'h33, 3, 2, K_NONE, 0, 0);
    send_byte(8'h44, 3, 2, K_NONE, 0, 0);
    send_byte(8'h44, 3, 10, K_NONE, 0, 0);
    check_busy("mid_post", 1'b0);
    drain("mid");
  endtask

  task automatic test_ev_beats_timeout;
    send_byte(8'hA5, 1, 2, K_NONE, 0, 0);
    send_byte(8'h10, 1, 2, K_NONE, 0, 0);
    send_byte(8'h20, 1, 2, K_NONE, 0, 0);
    send_byte(8'h30, 1, 2, K_NONE, 0, 0);
    send_byte(8'h40, 1, 4999, K_NONE, 0, 0);
    check_busy("race_wait", 1'b1);
    send_byte(8'h40, 1, 10, K_FV, 32'h40302010, 1);
    last_good = 32'h40302010;
    drain("race");
    check_busy("race_end", 1'b0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_error();
    test_sync_hunt();
    test_timeout();
    test_mid_reset();
    test_ev_beats_timeout();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
